lead_one_isolate: RTL and testbench
===================================

// Module: lead_one_isolate
// PURPOSE
//  Upstream stage of get_pow. Accepts arbitrary WIDTH-bit unsigned values over valid/ready,
//  finds the most-significant set bit by a serial MSB-first scan, and emits the isolated
//  one-hot value, which get_pow turns into floor(log2). Also flags zero input, for which
//  log2 is undefined. Multi-cycle, one transaction in flight, no pipelining.
// PARAMETERS
//  WIDTH   8   data width; must equal the get_pow input width (8)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      upstream value valid
//  in_ready    out  1      stage can accept (high only in IDLE)
//  in_num      in   WIDTH  value to normalise
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream (get_pow consumer) accepts result
//  out_onehot  out  WIDTH  1<<msb(in_num); all-zero when in_num==0
//  out_zero    out  1      1 when in_num==0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_onehot=0, out_zero=0,
//    internal value/index registers cleared. A scan in progress is discarded, not resumed.
//  - FSM states: IDLE, SCAN, DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_num into num_q, idx<=WIDTH-1, go SCAN.
//  - SCAN: in_ready=0. Each cycle test num_q[idx]:
//      set         -> out_onehot<=1<<idx, out_zero<=0, go DONE
//      clear, idx>0 -> idx<=idx-1, stay SCAN
//      clear, idx==0 -> out_onehot<=0, out_zero<=1, go DONE
//  - DONE: out_valid=1, outputs held stable; on out_ready go IDLE (out_valid drops next cycle).
//  - Latency: handshake in cycle t, MSB at position p -> out_valid first high in cycle
//    t+2+(WIDTH-1-p). Zero input: t+1+WIDTH. Throughput: no accept while SCAN/DONE.
//  - in_ready is combinational from state only (no path from in_valid/out_ready).
//  - out_valid never drops without out_ready; outputs stable while out_valid&&!out_ready.
//  - idx is $clog2(WIDTH) bits, unsigned; never decrements below 0.
//  - in_num is sampled only at the handshake; later changes have no effect.
// CONFIGURATION
//  - Macro LOG_STATS_EN. Defined: extra ports
//      stat_total  out 16  count of completed results (DONE && out_ready)
//      stat_zeros  out 16  count of completed results with out_zero=1
//    both reset to 0, wrap at 16'hFFFF -> 0, increment in the completion cycle.
//  - Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - log_pkg: WIDTH default constant, IDX_W=$clog2(WIDTH), state encoding
//    (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), STAT_W=16.
//  - One sub-module under LOG_STATS_EN only: log_stats_cnt (two wrapping counters,
//    inc/inc_zero inputs). Core FSM and scan datapath stay in this module.
// TESTING
//  1. in_num=8'h80 at t -> out_valid at t+2, out_onehot=8'h80, out_zero=0.
//  2. in_num=8'h2C at t -> out_valid at t+4, out_onehot=8'h20; get_pow yields 5.
//  3. in_num=8'h01 -> out_onehot=8'h01 at t+9; in_num=8'h00 -> out_onehot=0, out_zero=1 at t+9.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0,
//     new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. rst pulse mid-SCAN (in_num=8'h03) -> immediate IDLE, out_valid=0, in_ready=1;
//     next value 8'h40 -> out_onehot=8'h40 with normal latency.
//  6. LOG_STATS_EN: send 8'h00,8'h10,8'h00 back-to-back -> stat_total=3, stat_zeros=2;
//     force stat_total=16'hFFFF then complete one -> 0.

Source files
------------

// File: rtl/log_pkg.sv
// Shared constants and state encoding for the lead-one isolation stage.
// The optional result counters are enabled with the LOG_STATS_EN macro.
package log_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int IDX_W     = $clog2(DEF_WIDTH);
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/log_stats_cnt.sv
// Two wrapping result counters: all completed results and zero-input results.
// Only instantiated by lead_one_isolate when LOG_STATS_EN is defined.
module log_stats_cnt
    import log_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         inc_zero,
    output logic [W-1:0] total,
    output logic [W-1:0] zeros
);

    logic [W-1:0] total_q, total_d;
    logic [W-1:0] zeros_q, zeros_d;

    // Counters wrap naturally at all-ones.
    always_comb begin
        total_d = total_q;
        zeros_d = zeros_q;
        if (inc) begin
            total_d = total_q + W'(1);
        end
        if (inc_zero) begin
            zeros_d = zeros_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            zeros_q <= '0;
        end else begin
            total_q <= total_d;
            zeros_q <= zeros_d;
        end
    end

    assign total = total_q;
    assign zeros = zeros_q;

endmodule

// File: rtl/lead_one_isolate.sv
// Serial MSB-first scan that isolates the leading one of a value (feeds get_pow).
// Define LOG_STATS_EN to add the stat_total / stat_zeros result counters.
module lead_one_isolate
    import log_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_onehot,
    output logic              out_zero
`ifdef LOG_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_zeros
`endif
);

    localparam int IW = $clog2(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds
    // its data until out_ready.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            num_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_d   = in_num;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // One bit per cycle from the top; bit 0 clear means the value was zero.
                if (num_q[idx_q]) begin
                    onehot_d        = '0;
                    onehot_d[idx_q] = 1'b1;
                    zero_d          = 1'b0;
                    state_d         = DONE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IW'(1);
                end else begin
                    onehot_d = '0;
                    zero_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_onehot = onehot_q;
        out_zero   = zero_q;
    end

`ifdef LOG_STATS_EN
    logic done_fire;
    assign done_fire = (state_q == DONE) && out_ready;

    log_stats_cnt #(.W(STAT_W)) u_stats (
        .clk      (clk),
        .rst      (rst),
        .inc      (done_fire),
        .inc_zero (done_fire && zero_q),
        .total    (stat_total),
        .zeros    (stat_zeros)
    );
`endif

endmodule

// File: tb/tb_lead_one_isolate.sv
// Self-checking bench for lead_one_isolate; define LOG_STATS_EN to also
// exercise the result counters.
module tb_lead_one_isolate;

    localparam int W  = 8;
    localparam int EW = 17; // {latency[7:0], zero, onehot[7:0]}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_num = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_onehot;
    logic         out_zero;
`ifdef LOG_STATS_EN
    logic [15:0]  stat_total;
    logic [15:0]  stat_zeros;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    lead_one_isolate #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_num     (in_num),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_zero   (out_zero)
`ifdef LOG_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_zeros (stat_zeros)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [W-1:0] v);
        int p;
        logic [W-1:0] oh;
        logic [7:0] lat;
        p = -1;
        for (int i = 0; i < W; i++) if (v[i]) p = i;
        oh = '0;
        if (p >= 0) begin
            oh[p] = 1'b1;
            lat = 8'(1 + (W - 1 - p));
        end else begin
            lat = 8'(W);
        end
        return {lat, (p < 0), oh};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] v, input bit push, output int hs);
        bit ok;
        ok = 1'b0;
        hs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
            return;
        end
        if (push) exp_q.push_back(model(v));
        in_valid = 1'b1;
        in_num   = v;
        @(posedge clk);
        @(negedge clk);
        hs = cyc;
        in_valid = 1'b0;
        in_num   = W'($urandom_range(0, 255)); // must be ignored after the handshake
    endtask

    // Scoreboard pop: waits for out_valid, checks latency/data, then accepts.
    task automatic drain(input int hs, input int hold);
        logic [EW-1:0] e;
        bit seen;
        int lat;
        seen = 1'b0;
        e = exp_q.pop_front();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!seen) begin
            $display("FAIL out_valid_timeout: out_valid=0 required=1");
            return;
        end
        pass_cnt++;
        lat = cyc - hs;
        total_cnt++;
        if (lat !== int'(e[16:9])) $display("FAIL latency: got %0d required %0d", lat, e[16:9]);
        else pass_cnt++;
        total_cnt++;
        if ({out_zero, out_onehot} !== e[8:0])
            $display("FAIL result: zero/onehot=%b/%h required %b/%h", out_zero, out_onehot, e[8], e[7:0]);
        else pass_cnt++;
        for (int i = 0; i < hold; i++) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL after_accept: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== '0 || out_zero !== 1'b0)
            $display("FAIL reset_state: rdy=%b vld=%b oh=%h z=%b required 1/0/00/0",
                     in_ready, out_valid, out_onehot, out_zero);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] vals [4];
        int hs;
        vals = '{8'h80, 8'h2C, 8'h01, 8'h00};
        for (int i = 0; i < 4; i++) begin
            send(vals[i], 1'b1, hs);
            drain(hs, 0);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        bit seen;
        logic [EW-1:0] e;
        seen = 1'b0;
        e = model(8'h2C);
        send(8'h2C, 1'b0, hs);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        in_valid = 1'b1;
        in_num   = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_zero, out_onehot} !== e[8:0])
                $display("FAIL backpressure_hold: vld=%b rdy=%b z/oh=%b/%h required 1/0/%b/%h",
                         out_valid, in_ready, out_zero, out_onehot, e[8], e[7:0]);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int hs;
        send(8'h03, 1'b0, hs);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== '0 || out_zero !== 1'b0)
            $display("FAIL mid_scan_reset: rdy=%b vld=%b oh=%h z=%b required 1/0/00/0",
                     in_ready, out_valid, out_onehot, out_zero);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        send(8'h40, 1'b1, hs);
        drain(hs, 0);
    endtask

    task automatic test_back_to_back();
        int hs;
        logic [W-1:0] v;
        for (int i = 0; i < 10; i++) begin
            v = W'($urandom_range(0, 255) >> $urandom_range(0, 8));
            send(v, 1'b1, hs);
            drain(hs, $urandom_range(0, 2));
        end
    endtask

`ifdef LOG_STATS_EN
    task automatic test_stats();
        logic [W-1:0] vals [3];
        int hs;
        vals = '{8'h00, 8'h10, 8'h00};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vals[i], 1'b1, hs);
            drain(hs, 0);
        end
        total_cnt++;
        if (stat_total !== 16'd3 || stat_zeros !== 16'd2)
            $display("FAIL stats_count: total=%0d zeros=%0d required 3/2", stat_total, stat_zeros);
        else pass_cnt++;
        force dut.u_stats.total_q = 16'hFFFF;
        @(negedge clk);
        release dut.u_stats.total_q;
        send(8'h05, 1'b1, hs);
        drain(hs, 0);
        total_cnt++;
        if (stat_total !== 16'd0)
            $display("FAIL stats_wrap: total=%h required 0000", stat_total);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
`ifdef LOG_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
